// File: rtl/m3_pkg.sv
// m3_pkg: shared state encoding, step table and gate bit positions for the 3-phase commutation path.
package m3_pkg;
    typedef enum logic [1:0] {IDLE, DEAD, DRIVE} stateT;
    localparam int M3_MIN_LEN = 40;
    localparam int STEPS = 6;
    localparam int PH_UH = 5, PH_UL = 4, PH_VH = 3, PH_VL = 2, PH_WH = 1, PH_WL = 0;
    localparam logic [5:0] STEP_TAB [STEPS] = '{
        6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110
    };
    function automatic logic [2:0] nextStep(input logic [2:0] idx, input logic inv);
        return inv ? (idx == 3'd0 ? 3'd5 : idx - 3'd1) : (idx == 3'd5 ? 3'd0 : idx + 3'd1);
    endfunction
endpackage

// File: rtl/m3_commutation_step_gen_if.sv
// m3_commutation_step_gen_if: control inputs and gate/status outputs of the commutation sequencer.
interface m3_commutation_step_gen_if #(parameter int LEN_W = 32);
    logic [LEN_W-1:0] roundLenI;
    logic workingI, m3invRotateI, m3forceStopI;
    logic [5:0] phaseO;
    logic [2:0] stepIdxO;
    logic nextRound_1O, busyO;
    modport master(
        output roundLenI, workingI, m3invRotateI, m3forceStopI,
        input phaseO, stepIdxO, nextRound_1O, busyO
    );
    modport slave(
        input roundLenI, workingI, m3invRotateI, m3forceStopI,
        output phaseO, stepIdxO, nextRound_1O, busyO
    );
endinterface

// File: rtl/m3_step_accum.sv
// m3_step_accum: fractional step timer; ticks every lenLat/INC cycles on average without a divider.
module m3_step_accum #(
    parameter int LEN_W = 32,
    parameter int INC = 6
) (
    input logic clkI,
    input logic nRstI,
    input logic [LEN_W-1:0] lenLat,
    input logic enable,
    input logic clear,
    output logic stepTick
);
    logic [LEN_W-1:0] acc;
    logic [LEN_W:0] sum;
    assign sum = {1'b0, acc} + (LEN_W + 1)'(INC);
    assign stepTick = enable && sum >= {1'b0, lenLat};
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) acc <= '0;
        else if (clear) acc <= '0;
        else if (enable) acc <= stepTick ? LEN_W'(sum - {1'b0, lenLat}) : sum[LEN_W-1:0];
    end
endmodule

// File: rtl/m3_commutation_step_gen.sv
// m3_commutation_step_gen: six-step bridge sequencer with dead-time and one pulse per electrical round.
module m3_commutation_step_gen
    import m3_pkg::*;
#(
    parameter int DEAD_CYCLES = 2,
    parameter int MIN_LEN = M3_MIN_LEN,
    parameter int LEN_W = 32
) (
    input logic clkI,
    input logic nRstI,
    m3_commutation_step_gen_if.slave bus
);
    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);
    if (DEAD_CYCLES < 1 || DEAD_CYCLES >= MIN_LEN / STEPS) begin : gDeadCheck
        $error("DEAD_CYCLES must lie in 1 .. MIN_LEN/6-1");
    end
    stateT state, stateD;
    logic [2:0] stepIdx, stepD, advIdx;
    logic [CNT_W-1:0] deadCnt, cntD;
    logic [LEN_W-1:0] lenLat, lenD, lenClamp;
    logic nextRound, roundD, stop, run, stepTick;
    assign stop = !bus.workingI || bus.m3forceStopI;
    assign run = state != IDLE && !stop;
    assign lenClamp = bus.roundLenI < LEN_W'(MIN_LEN) ? LEN_W'(MIN_LEN) : bus.roundLenI;
    assign advIdx = nextStep(stepIdx, bus.m3invRotateI);
    m3_step_accum #(.LEN_W(LEN_W), .INC(STEPS)) uAccum (
        .clkI, .nRstI, .lenLat, .enable(run), .clear(!run), .stepTick
    );
    // a step boundary always wins over the dead countdown; lenLat only moves on entry to step 0
    always_comb begin
        stateD = state;
        stepD = stepIdx;
        cntD = deadCnt;
        lenD = lenLat;
        roundD = 1'b0;
        if (stop) begin
            stateD = IDLE;
            stepD = '0;
            cntD = '0;
        end else if (state == IDLE) begin
            stateD = DEAD;
            stepD = '0;
            cntD = CNT_W'(DEAD_CYCLES);
            lenD = lenClamp;
        end else if (stepTick) begin
            stateD = DEAD;
            stepD = advIdx;
            cntD = CNT_W'(DEAD_CYCLES);
            roundD = advIdx == 3'd0;
            lenD = advIdx == 3'd0 ? lenClamp : lenLat;
        end else if (state == DEAD) begin
            stateD = deadCnt == CNT_W'(1) ? DRIVE : DEAD;
            cntD = deadCnt - CNT_W'(1);
        end
    end
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state <= IDLE;
            stepIdx <= '0;
            deadCnt <= '0;
            lenLat <= LEN_W'(MIN_LEN);
            nextRound <= 1'b0;
        end else begin
            state <= stateD;
            stepIdx <= stepD;
            deadCnt <= cntD;
            lenLat <= lenD;
            nextRound <= roundD;
        end
    end
    assign bus.phaseO = state == DRIVE ? STEP_TAB[stepIdx] : 6'd0;
    assign bus.stepIdxO = stepIdx;
    assign bus.nextRound_1O = nextRound;
    assign bus.busyO = state != IDLE;
endmodule

// File: tb/tb_m3_commutation_step_gen.sv
// tb_m3_commutation_step_gen: directed runs feed an event scoreboard; a monitor checks every cycle.
module tb_m3_commutation_step_gen;
    import m3_pkg::*;
    localparam int DEAD = 2;
    typedef struct packed {
        logic busy;
        logic [2:0] idx;
        logic rnd;
        logic [15:0] len;
    } evT;
    localparam logic [5:0] TAB [6] = '{
        6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110
    };
    logic clkI = 1'b0;
    logic nRstI = 1'b0;
    m3_commutation_step_gen_if #(.LEN_W(32)) bus ();
    m3_commutation_step_gen #(.DEAD_CYCLES(DEAD), .MIN_LEN(40), .LEN_W(32)) dut (
        .clkI(clkI), .nRstI(nRstI), .bus(bus)
    );
    always #5 clkI = ~clkI;

    evT expQ[$];
    evT ev;
    int lens[$];
    int total = 0, passed = 0;
    bit freeRun = 1'b0;
    int cyc = 0, lastEv = 0, since = 0;
    logic pBusy = 1'b0;
    logic [2:0] pIdx = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Every change of (busyO, stepIdxO) is an event; the directed runs predict each one in order.
    always @(posedge clkI) begin
        #1;
        if (nRstI) begin
            cyc++;
            if (bus.busyO !== pBusy || bus.stepIdxO !== pIdx) begin
                if (freeRun) begin
                    check("round pulse", bus.nextRound_1O, bus.busyO && pBusy && bus.stepIdxO == 3'd0);
                    if (bus.busyO && pBusy)
                        check("step order", (int'(bus.stepIdxO) == (int'(pIdx) + 1) % 6) ||
                              (int'(bus.stepIdxO) == (int'(pIdx) + 5) % 6), 1);
                end else if (expQ.size() == 0) begin
                    check("unexpected event", {bus.busyO, bus.stepIdxO}, {pBusy, pIdx});
                end else begin
                    ev = expQ.pop_front();
                    check("event busy/idx/round", {bus.busyO, bus.stepIdxO, bus.nextRound_1O},
                          {ev.busy, ev.idx, ev.rnd});
                    if (ev.len != 0) check("event spacing", cyc - lastEv, ev.len);
                end
                lastEv = cyc;
                since = 0;
            end else begin
                check("no stray round pulse", bus.nextRound_1O, 0);
            end
            check("phase", bus.phaseO, !bus.busyO || since < DEAD ? 6'd0 : TAB[bus.stepIdxO]);
            check("no shoot-through", (bus.phaseO[PH_UH] & bus.phaseO[PH_UL]) |
                  (bus.phaseO[PH_VH] & bus.phaseO[PH_VL]) | (bus.phaseO[PH_WH] & bus.phaseO[PH_WL]), 0);
            if (!bus.busyO) check("idle step", bus.stepIdxO, 0);
            since++;
            pBusy = bus.busyO;
            pIdx = bus.stepIdxO;
        end
    end

    task automatic push(input logic b, input int idx, input logic r, input int l);
        expQ.push_back('{busy: b, idx: 3'(idx), rnd: r, len: 16'(l)});
    endtask

    task automatic addLens(input int l, input int n);
        repeat (n) lens.push_back(l);
    endtask

    // Start at the next edge, expect one event per entry in lens, then stop 4 cycles after the last entry.
    task automatic run(input int rl, input logic inv, input int chgAt, input int chgLen, input logic useForce);
        int idx = 0;
        int e = 1;
        push(1'b1, 0, 1'b0, 0);
        foreach (lens[j]) begin
            idx = inv ? (idx + 5) % 6 : (idx + 1) % 6;
            e += lens[j];
            push(1'b1, idx, idx == 0, lens[j]);
        end
        push(1'b0, 0, 1'b0, 4);
        bus.roundLenI = rl;
        bus.m3invRotateI = inv;
        bus.m3forceStopI = 1'b0;
        bus.workingI = 1'b1;
        for (int m = 1; m <= e + 3; m++) begin
            @(negedge clkI);
            if (m == chgAt) bus.roundLenI = chgLen;
        end
        if (useForce) bus.m3forceStopI = 1'b1;
        else bus.workingI = 1'b0;
        lens.delete();
        repeat (3) @(negedge clkI);
    endtask

    initial begin
        bus.roundLenI = 60;
        bus.workingI = 1'b0;
        bus.m3invRotateI = 1'b0;
        bus.m3forceStopI = 1'b0;
        repeat (2) @(negedge clkI);
        check("reset phaseO", bus.phaseO, 0);
        check("reset stepIdxO", bus.stepIdxO, 0);
        check("reset nextRound_1O", bus.nextRound_1O, 0);
        check("reset busyO", bus.busyO, 0);
        nRstI = 1'b1;
        repeat (2) @(negedge clkI);
        addLens(10, 12);
        run(60, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin addLens(7, 2); addLens(6, 1); end
        run(40, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin addLens(7, 2); addLens(6, 1); end
        run(10, 1'b0, 0, 0, 1'b0);
        addLens(10, 12);
        run(60, 1'b1, 0, 0, 1'b0);
        addLens(10, 6);
        addLens(20, 6);
        run(60, 1'b0, 30, 120, 1'b0);
        addLens(10, 3);
        run(60, 1'b0, 0, 0, 1'b1);
        addLens(10, 6);
        run(60, 1'b0, 0, 0, 1'b0);
        freeRun = 1'b1;
        bus.workingI = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clkI);
            if ($urandom_range(0, 29) == 0) bus.m3invRotateI = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) bus.roundLenI = $urandom_range(0, 150);
        end
        bus.workingI = 1'b0;
        repeat (4) @(negedge clkI);
        freeRun = 1'b0;
        for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge clkI);
        check("scoreboard drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
